// File: rtl/brightness_ctrl.sv
// Frame controller for the brightness datapath: latches the adjustment config,
// loads a frame of pixels, then streams processed pixels out with backpressure.
module brightness_ctrl #(
  parameter int WIDTH  = 361,
  parameter int DEPTH  = 410,
  parameter int PIXELS = WIDTH * DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       cfg_do_bright,
  input  logic [7:0] cfg_bright,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       dp_rst,
  output logic       enable,
  output logic       enable_process,
  output logic       do_bright,
  output logic [7:0] bright,
  output logic       busy,
  output logic       done
);

  localparam logic [31:0] PIXELS_W = 32'(PIXELS);
  localparam logic [31:0] LAST_PIX = 32'(PIXELS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    PROC,
    DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] load_cnt_q, load_cnt_d;
  logic [31:0] proc_cnt_q, proc_cnt_d;
  logic        do_bright_q, do_bright_d;
  logic [7:0]  bright_q, bright_d;
  logic        out_valid_q, out_valid_d;
  logic        done_q, done_d;
  logic        dp_hold_q, dp_hold_d;

  always_comb begin
    state_d        = state_q;
    load_cnt_d     = load_cnt_q;
    proc_cnt_d     = proc_cnt_q;
    do_bright_d    = do_bright_q;
    bright_d       = bright_q;
    out_valid_d    = out_valid_q;
    done_d         = 1'b0;
    dp_hold_d      = 1'b0;
    in_ready       = 1'b0;
    enable         = 1'b0;
    enable_process = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          do_bright_d = cfg_do_bright;
          bright_d    = cfg_bright;
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        load_cnt_d = '0;
        proc_cnt_d = '0;
        state_d    = LOAD;
      end
      LOAD: begin
        in_ready = !abort;
        enable   = in_valid && in_ready;
        if (enable) begin
          load_cnt_d = load_cnt_q + 32'd1;
          if (load_cnt_q == LAST_PIX) begin
            state_d = PROC;
          end
        end
      end
      PROC: begin
        // A new strobe is only allowed once the pending output slot is free.
        enable_process = !abort && (proc_cnt_q < PIXELS_W) && (!out_valid_q || out_ready);
        if (enable_process) begin
          proc_cnt_d  = proc_cnt_q + 32'd1;
          out_valid_d = 1'b1;
          if (proc_cnt_q == LAST_PIX) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything else; the datapath reset follows in the next cycle.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
      dp_hold_d   = 1'b1;
      load_cnt_d  = '0;
      proc_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      load_cnt_q  <= '0;
      proc_cnt_q  <= '0;
      do_bright_q <= 1'b0;
      bright_q    <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      dp_hold_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      proc_cnt_q  <= proc_cnt_d;
      do_bright_q <= do_bright_d;
      bright_q    <= bright_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      dp_hold_q   <= dp_hold_d;
    end
  end

  assign dp_rst    = rst || dp_hold_q || (state_q == CLEAR);
  assign out_valid = out_valid_q;
  assign do_bright = do_bright_q;
  assign bright    = bright_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule
